// File: rtl/coupled_stdp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : coupled_stdp_pkg
// Purpose: Shared types and constants for the coupled Izhikevich-pair step
//          scheduler: FSM state encoding, the per-synapse STDP request record,
//          the spike-age saturation value and the request-building rule.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package coupled_stdp_pkg;

    // Step counter / spike age / dt width. The scheduler's Q parameter must
    // match this value because the request record is sized from it.
    localparam int Q_W = 16;

    // Ages saturate here instead of wrapping.
    localparam logic [Q_W-1:0] AGE_MAX = {Q_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        SYN0  = 3'd4,
        SYN1  = 3'd5
    } state_t;

    typedef struct packed {
        logic           valid;
        logic           ltp;
        logic [Q_W-1:0] dt;
    } stdp_req_t;

    // Builds the request for one synapse from its pre/post neurons.
    // Post fires alone after a recent pre spike -> potentiate with the pre age.
    // Pre fires alone after a recent post spike -> depress with the post age.
    // A saturated age means "too long ago" even if the window reaches AGE_MAX.
    function automatic stdp_req_t make_req(
        input logic           pre_spk,
        input logic           post_spk,
        input logic           pre_vld,
        input logic           post_vld,
        input logic [Q_W-1:0] dt_pre,
        input logic [Q_W-1:0] dt_post,
        input logic [Q_W-1:0] window
    );
        stdp_req_t r;
        r = '0;
        if (post_spk && !pre_spk && pre_vld &&
            (dt_pre <= window) && (dt_pre != AGE_MAX)) begin
            r.valid = 1'b1;
            r.ltp   = 1'b1;
            r.dt    = dt_pre;
        end else if (pre_spk && !post_spk && post_vld &&
                     (dt_post <= window) && (dt_post != AGE_MAX)) begin
            r.valid = 1'b1;
            r.ltp   = 1'b0;
            r.dt    = dt_post;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coupled_stdp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : coupled_stdp_scheduler_if
// Purpose: Bundles the step-control, neuron-datapath and STDP-unit signals of
//          the coupled STDP scheduler.
// Ports  : slave  - scheduler side (receives apply/neuron_done/spikes/ready,
//                   drives neuron_start, STDP request, busy, overrun, count)
//          master - environment side (the mirror image)
// Rev    : 1.0  initial release
// ============================================================================
interface coupled_stdp_scheduler_if #(
    parameter int Q = coupled_stdp_pkg::Q_W
);
    // Environment -> scheduler
    logic         apply;
    logic         neuron_done;
    logic         is_spiking1;
    logic         is_spiking2;
    logic         stdp_ready;

    // Scheduler -> environment
    logic         neuron_start;
    logic         stdp_valid;
    logic         stdp_syn;
    logic         stdp_ltp;
    logic [Q-1:0] stdp_dt;
    logic         busy;
    logic         overrun;
    logic [Q-1:0] step_count;

    modport slave (
        input  apply, neuron_done, is_spiking1, is_spiking2, stdp_ready,
        output neuron_start, stdp_valid, stdp_syn, stdp_ltp, stdp_dt,
               busy, overrun, step_count
    );

    modport master (
        output apply, neuron_done, is_spiking1, is_spiking2, stdp_ready,
        input  neuron_start, stdp_valid, stdp_syn, stdp_ltp, stdp_dt,
               busy, overrun, step_count
    );

endinterface

`default_nettype wire

// File: rtl/coupled_stdp_scheduler_spike_age_tracker.sv
`default_nettype none
// ============================================================================
// Module : spike_age_tracker
// Purpose: Holds the number of steps since one neuron last spiked and whether
//          it has spiked at all since reset. Exposes the saturating interval
//          dt = age + 1 seen by the step under evaluation, and applies the
//          end-of-evaluation update.
// Ports  : clk, rst   - clock, synchronous active-high reset
//          update_i   - one-cycle strobe: commit this step's age update
//          spike_i    - neuron spiked in the step being evaluated
//          dt_o       - saturating age + 1 (steps since last spike)
//          valid_o    - neuron has spiked at least once since reset
// Rev    : 1.0  initial release
// ============================================================================
module spike_age_tracker
    import coupled_stdp_pkg::*;
#(
    parameter int Q = Q_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         update_i,
    input  logic         spike_i,
    output logic [Q-1:0] dt_o,
    output logic         valid_o
);

    localparam logic [Q-1:0] C_SAT = {Q{1'b1}};

    logic [Q-1:0] age_q, age_d;
    logic         valid_q, valid_d;

    // Interval to the previous spike as seen from the current step.
    always_comb begin
        if (age_q == C_SAT) begin
            dt_o = C_SAT;
        end else begin
            dt_o = age_q + Q'(1);
        end
    end

    always_comb begin
        age_d   = age_q;
        valid_d = valid_q;
        if (update_i) begin
            if (spike_i) begin
                age_d   = '0;
                valid_d = 1'b1;
            end else if (valid_q) begin
                age_d   = dt_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/coupled_stdp_scheduler.sv
`default_nettype none
// ============================================================================
// Module : coupled_stdp_scheduler
// Purpose: Sequences one simulation step of a two-neuron Izhikevich pair with
//          STDP learning. On apply: pulses neuron_start, waits for
//          neuron_done, latches both spike flags, evaluates the two synapse
//          requests from the neurons' spike ages, then presents up to two STDP
//          weight-update requests (synapse 0 = n1->n2 / w1 first, synapse 1 =
//          n2->n1 / w2 second) over a valid/ready handshake.
// Ports  : clk        - clock, rising edge
//          rst        - synchronous active-high reset
//          sched_if   - slave side of coupled_stdp_scheduler_if:
//                       apply, neuron_done, is_spiking1/2, stdp_ready in;
//                       neuron_start, stdp_valid/syn/ltp/dt, busy, overrun,
//                       step_count out
// Params : N      - datapath word width (no arithmetic on it here)
//          Q      - step counter / age / dt width (must equal Q_W)
//          WINDOW - largest dt for which a request is issued
// Rev    : 1.0  initial release
// ============================================================================
module coupled_stdp_scheduler
    import coupled_stdp_pkg::*;
#(
    parameter int N      = 32,
    parameter int Q      = Q_W,
    parameter int WINDOW = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    coupled_stdp_scheduler_if.slave  sched_if
);

    localparam bit PARAMS_OK = (N > 0) && (Q == Q_W) &&
                               (WINDOW >= 1) && (WINDOW <= int'(AGE_MAX));

    // An illegal parameter set elaborates this marker block; it is visible
    // in the elaborated hierarchy of any tool.
    if (!PARAMS_OK) begin : g_bad_params
    end

    localparam logic [Q_W-1:0] C_WIN = Q_W'(WINDOW);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic         spk1_q, spk1_d;
    logic         spk2_q, spk2_d;
    stdp_req_t    req0_q, req0_d;
    stdp_req_t    req1_q, req1_d;
    logic [Q-1:0] step_q, step_d;
    logic         overrun_q, overrun_d;

    // Combinational outputs of the FSM
    logic         eval_en;
    logic         start;
    logic         req_valid;
    logic         req_syn;
    logic         req_ltp;
    logic [Q-1:0] req_dt;

    // Age trackers
    logic [Q-1:0] dt1, dt2;
    logic         vld1, vld2;
    stdp_req_t    req0_new, req1_new;

    spike_age_tracker #(
        .Q        (Q)
    ) u_age1 (
        .clk      (clk),
        .rst      (rst),
        .update_i (eval_en),
        .spike_i  (spk1_q),
        .dt_o     (dt1),
        .valid_o  (vld1)
    );

    spike_age_tracker #(
        .Q        (Q)
    ) u_age2 (
        .clk      (clk),
        .rst      (rst),
        .update_i (eval_en),
        .spike_i  (spk2_q),
        .dt_o     (dt2),
        .valid_o  (vld2)
    );

    // Synapse 0: pre = n1, post = n2. Synapse 1: pre = n2, post = n1.
    always_comb begin
        req0_new = make_req(spk1_q, spk2_q, vld1, vld2, dt1, dt2, C_WIN);
        req1_new = make_req(spk2_q, spk1_q, vld2, vld1, dt2, dt1, C_WIN);
    end

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        spk1_d    = spk1_q;
        spk2_d    = spk2_q;
        req0_d    = req0_q;
        req1_d    = req1_q;
        step_d    = step_q;
        eval_en   = 1'b0;
        start     = 1'b0;
        req_valid = 1'b0;
        req_syn   = 1'b0;
        req_ltp   = 1'b0;
        req_dt    = '0;

        unique case (state_q)
            IDLE: begin
                if (sched_if.apply) begin
                    state_d = START;
                end
            end

            START: begin
                start   = 1'b1;
                state_d = WAIT;
            end

            WAIT: begin
                if (sched_if.neuron_done) begin
                    spk1_d  = sched_if.is_spiking1;
                    spk2_d  = sched_if.is_spiking2;
                    state_d = EVAL;
                end
            end

            EVAL: begin
                // Requests are computed from the ages before this step's
                // update; the trackers commit on the same edge.
                req0_d  = req0_new;
                req1_d  = req1_new;
                step_d  = step_q + Q'(1);
                eval_en = 1'b1;
                state_d = SYN0;
            end

            SYN0: begin
                if (req0_q.valid) begin
                    req_valid = 1'b1;
                    req_syn   = 1'b0;
                    req_ltp   = req0_q.ltp;
                    req_dt    = req0_q.dt;
                    if (sched_if.stdp_ready) begin
                        state_d = SYN1;
                    end
                end else begin
                    state_d = SYN1;
                end
            end

            SYN1: begin
                if (req1_q.valid) begin
                    req_valid = 1'b1;
                    req_syn   = 1'b1;
                    req_ltp   = req1_q.ltp;
                    req_dt    = req1_q.dt;
                    if (sched_if.stdp_ready) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A request arriving while a step is in flight is dropped and flagged.
    assign overrun_d = sched_if.apply && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            spk1_q    <= 1'b0;
            spk2_q    <= 1'b0;
            req0_q    <= '0;
            req1_q    <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            spk1_q    <= spk1_d;
            spk2_q    <= spk2_d;
            req0_q    <= req0_d;
            req1_q    <= req1_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sched_if.neuron_start = start;
    assign sched_if.stdp_valid   = req_valid;
    assign sched_if.stdp_syn     = req_syn;
    assign sched_if.stdp_ltp     = req_ltp;
    assign sched_if.stdp_dt      = req_dt;
    assign sched_if.busy         = (state_q != IDLE);
    assign sched_if.overrun      = overrun_q;
    assign sched_if.step_count   = step_q;

endmodule

`default_nettype wire

// File: tb/tb_coupled_stdp_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_coupled_stdp_scheduler
// Purpose: Self-checking bench for coupled_stdp_scheduler. A reference model
//          remembers the step index of each neuron's last spike and derives
//          expected STDP requests and step counts from those indices.
// Rev    : 1.0  initial release
// ============================================================================
module tb_coupled_stdp_scheduler;

    localparam int Q       = 16;
    localparam int WINDOW  = 64;
    localparam int AGE_MAX = 65535;

    typedef struct {
        bit syn;
        bit ltp;
        int dt;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    coupled_stdp_scheduler_if #(.Q(Q)) sif ();

    coupled_stdp_scheduler #(
        .N        (32),
        .Q        (Q),
        .WINDOW   (WINDOW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (sif)
    );

    int   checks   = 0;
    int   failures = 0;

    // Reference model state: step index of last spike, -1 = never.
    int   m_step;
    int   m_last1;
    int   m_last2;
    req_t exp_q[$];
    req_t obs_q[$];

    function automatic void model_reset();
        m_step  = 0;
        m_last1 = -1;
        m_last2 = -1;
        exp_q.delete();
    endfunction

    function automatic int interval(input int last);
        int d;
        if (last < 0) return -1;
        d = m_step - last;
        return (d > AGE_MAX) ? AGE_MAX : d;
    endfunction

    function automatic void model_syn(input bit syn, input bit pre, input bit post,
                                      input int dt_pre, input int dt_post);
        req_t r;
        r.syn = syn;
        if (post && !pre && dt_pre > 0 && dt_pre <= WINDOW && dt_pre < AGE_MAX) begin
            r.ltp = 1'b1;
            r.dt  = dt_pre;
            exp_q.push_back(r);
        end else if (pre && !post && dt_post > 0 && dt_post <= WINDOW && dt_post < AGE_MAX) begin
            r.ltp = 1'b0;
            r.dt  = dt_post;
            exp_q.push_back(r);
        end
    endfunction

    function automatic void model_step(input bit s1, input bit s2);
        int d1, d2;
        m_step++;
        d1 = interval(m_last1);
        d2 = interval(m_last2);
        model_syn(1'b0, s1, s2, d1, d2);
        model_syn(1'b1, s2, s1, d2, d1);
        if (s1) m_last1 = m_step;
        if (s2) m_last2 = m_step;
    endfunction

    // Runs one full step starting at a falling edge with the DUT idle.
    task automatic run_step(input bit s1, input bit s2, input int done_dly,
                            input int stall, input bit poke, output int busy_cycles);
        int   guard;
        int   stall_left;
        bit   expect_ovr;
        bit   poked;
        bit   exp0;
        req_t r;
        req_t o;
        model_step(s1, s2);
        busy_cycles = 0;
        sif.apply = 1'b1;
        @(negedge clk);
        sif.apply = 1'b0;
        if (sif.busy === 1'b1) busy_cycles++;
        checks++;
        if (sif.neuron_start !== 1'b1 || sif.busy !== 1'b1) begin
            failures++;
            $display("FAIL start_pulse: neuron_start=%b busy=%b, required 1 1",
                     sif.neuron_start, sif.busy);
        end
        @(negedge clk);
        if (sif.busy === 1'b1) busy_cycles++;
        for (int i = 0; i < done_dly; i++) begin
            sif.is_spiking1 = 1'($urandom_range(1));
            sif.is_spiking2 = 1'($urandom_range(1));
            checks++;
            if (sif.busy !== 1'b1 || sif.neuron_start !== 1'b0 || sif.stdp_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold: busy=%b neuron_start=%b stdp_valid=%b, required 1 0 0",
                         sif.busy, sif.neuron_start, sif.stdp_valid);
            end
            @(negedge clk);
            if (sif.busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (sif.neuron_start !== 1'b0) begin
            failures++;
            $display("FAIL start_single: neuron_start=%b in WAIT, required 0", sif.neuron_start);
        end
        sif.neuron_done = 1'b1;
        sif.is_spiking1 = s1;
        sif.is_spiking2 = s2;
        @(negedge clk);
        if (sif.busy === 1'b1) busy_cycles++;
        sif.neuron_done = 1'b0;
        sif.is_spiking1 = 1'($urandom_range(1));
        sif.is_spiking2 = 1'($urandom_range(1));
        checks++;
        if (sif.busy !== 1'b1 || sif.stdp_valid !== 1'b0) begin
            failures++;
            $display("FAIL eval_cycle: busy=%b stdp_valid=%b, required 1 0", sif.busy, sif.stdp_valid);
        end
        @(negedge clk);
        if (sif.busy === 1'b1) busy_cycles++;
        exp0 = (exp_q.size() > 0) && (exp_q[0].syn == 1'b0);
        checks++;
        if (sif.stdp_valid !== exp0) begin
            failures++;
            $display("FAIL first_valid_latency: stdp_valid=%b, required %b", sif.stdp_valid, exp0);
        end
        guard      = 0;
        stall_left = stall;
        expect_ovr = 1'b0;
        poked      = 1'b0;
        while (sif.busy === 1'b1 && guard < 200) begin
            sif.apply = 1'b0;
            checks++;
            if (sif.overrun !== expect_ovr) begin
                failures++;
                $display("FAIL overrun: overrun=%b, required %b", sif.overrun, expect_ovr);
            end
            expect_ovr = 1'b0;
            checks++;
            if (sif.neuron_start !== 1'b0) begin
                failures++;
                $display("FAIL start_extra: neuron_start=%b, required 0", sif.neuron_start);
            end
            if (sif.stdp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: syn=%b ltp=%b dt=%0d, required no request",
                             sif.stdp_syn, sif.stdp_ltp, sif.stdp_dt);
                    sif.stdp_ready = 1'b1;
                end else begin
                    r = exp_q[0];
                    checks++;
                    if (sif.stdp_syn !== r.syn || sif.stdp_ltp !== r.ltp || sif.stdp_dt !== 16'(r.dt)) begin
                        failures++;
                        $display("FAIL req_fields: syn=%b ltp=%b dt=%0d, required syn=%b ltp=%b dt=%0d",
                                 sif.stdp_syn, sif.stdp_ltp, sif.stdp_dt, r.syn, r.ltp, r.dt);
                    end
                    if (stall_left > 0) begin
                        sif.stdp_ready = 1'b0;
                        stall_left--;
                        if (poke && !poked) begin
                            sif.apply  = 1'b1;
                            poked      = 1'b1;
                            expect_ovr = 1'b1;
                        end
                    end else begin
                        sif.stdp_ready = 1'b1;
                        o.syn = sif.stdp_syn;
                        o.ltp = sif.stdp_ltp;
                        o.dt  = int'(sif.stdp_dt);
                        obs_q.push_back(o);
                        void'(exp_q.pop_front());
                        stall_left = stall;
                    end
                end
            end else begin
                sif.stdp_ready = 1'($urandom_range(1));
                checks++;
                if (sif.stdp_syn !== 1'b0 || sif.stdp_ltp !== 1'b0 || sif.stdp_dt !== '0) begin
                    failures++;
                    $display("FAIL idle_fields_zero: syn=%b ltp=%b dt=%0d, required 0 0 0",
                             sif.stdp_syn, sif.stdp_ltp, sif.stdp_dt);
                end
            end
            @(negedge clk);
            guard++;
            if (sif.busy === 1'b1) busy_cycles++;
        end
        sif.stdp_ready = 1'b0;
        sif.apply      = 1'b0;
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL step_timeout: busy still %b after %0d cycles, required 0", sif.busy, guard);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_req: %0d requests not seen, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (sif.step_count !== 16'(m_step % 65536) || sif.overrun !== expect_ovr) begin
            failures++;
            $display("FAIL step_count: step_count=%0d overrun=%b, required %0d %b",
                     sif.step_count, sif.overrun, m_step % 65536, expect_ovr);
        end
    endtask

    task automatic check_quiet(input string name, input int exp_count);
        checks++;
        if (sif.neuron_start !== 1'b0 || sif.stdp_valid !== 1'b0 || sif.stdp_syn !== 1'b0 ||
            sif.stdp_ltp !== 1'b0 || sif.stdp_dt !== '0 || sif.busy !== 1'b0 ||
            sif.overrun !== 1'b0 || sif.step_count !== 16'(exp_count)) begin
            failures++;
            $display("FAIL %s: start=%b valid=%b syn=%b ltp=%b dt=%0d busy=%b ovr=%b count=%0d, required all 0 count=%0d",
                     name, sif.neuron_start, sif.stdp_valid, sif.stdp_syn, sif.stdp_ltp,
                     sif.stdp_dt, sif.busy, sif.overrun, sif.step_count, exp_count);
        end
    endtask

    task automatic check_obs(input string name, input int idx, input bit syn,
                             input bit ltp, input int dt);
        checks++;
        if (obs_q.size() <= idx) begin
            failures++;
            $display("FAIL %s: only %0d requests seen, required entry %0d", name, obs_q.size(), idx);
        end else if (obs_q[idx].syn !== syn || obs_q[idx].ltp !== ltp || obs_q[idx].dt != dt) begin
            failures++;
            $display("FAIL %s: syn=%b ltp=%b dt=%0d, required syn=%b ltp=%b dt=%0d", name,
                     obs_q[idx].syn, obs_q[idx].ltp, obs_q[idx].dt, syn, ltp, dt);
        end
    endtask

    task automatic check_obs_count(input string name, input int n);
        checks++;
        if (obs_q.size() != n) begin
            failures++;
            $display("FAIL %s: %0d requests seen, required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs", 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_quiet("post_reset_idle", 0);
    endtask

    task automatic test_single_step();
        int bc;
        obs_q.delete();
        run_step(1'b0, 1'b0, 3, 0, 1'b0, bc);
        checks++;
        if (bc != 8) begin
            failures++;
            $display("FAIL single_step_busy: busy cycles=%0d, required 8", bc);
        end
        check_obs_count("single_step_no_req", 0);
        check_quiet("single_step_idle", 1);
    endtask

    task automatic test_min_step();
        int bc;
        run_step(1'b0, 1'b0, 0, 0, 1'b0, bc);
        checks++;
        if (bc != 5) begin
            failures++;
            $display("FAIL min_step_len: busy cycles=%0d, required 5", bc);
        end
    endtask

    task automatic test_pair();
        int bc;
        run_step(1'b1, 1'b0, 1, 0, 1'b0, bc);
        run_step(1'b0, 1'b0, 0, 0, 1'b0, bc);
        run_step(1'b0, 1'b0, 2, 0, 1'b0, bc);
        obs_q.delete();
        run_step(1'b0, 1'b1, 0, 1, 1'b0, bc);
        check_obs_count("pair_count", 2);
        check_obs("pair_syn0_ltp", 0, 1'b0, 1'b1, 3);
        check_obs("pair_syn1_ltd", 1, 1'b1, 1'b0, 3);
    endtask

    task automatic test_both();
        int bc;
        run_step(1'b1, 1'b0, 0, 0, 1'b0, bc);
        run_step(1'b0, 1'b1, 0, 0, 1'b0, bc);
        obs_q.delete();
        run_step(1'b1, 1'b1, 1, 0, 1'b0, bc);
        check_obs_count("both_spike_no_req", 0);
        obs_q.delete();
        run_step(1'b0, 1'b1, 0, 0, 1'b0, bc);
        check_obs_count("both_ages_zero_count", 2);
        check_obs("both_ages_zero_syn0", 0, 1'b0, 1'b1, 1);
        check_obs("both_ages_zero_syn1", 1, 1'b1, 1'b0, 1);
    endtask

    task automatic test_window();
        int bc;
        run_step(1'b1, 1'b0, 0, 0, 1'b0, bc);
        for (int i = 0; i < WINDOW; i++) run_step(1'b0, 1'b0, 0, 0, 1'b0, bc);
        obs_q.delete();
        run_step(1'b0, 1'b1, 0, 0, 1'b0, bc);
        check_obs_count("window_plus1_no_req", 0);
        run_step(1'b1, 1'b0, 0, 0, 1'b0, bc);
        for (int i = 0; i < WINDOW - 1; i++) run_step(1'b0, 1'b0, 0, 0, 1'b0, bc);
        obs_q.delete();
        run_step(1'b0, 1'b1, 0, 0, 1'b0, bc);
        check_obs_count("window_exact_count", 2);
        check_obs("window_exact_syn0", 0, 1'b0, 1'b1, WINDOW);
        check_obs("window_exact_syn1", 1, 1'b1, 1'b0, WINDOW);
    endtask

    task automatic test_stall();
        int bc;
        run_step(1'b1, 1'b0, 0, 0, 1'b0, bc);
        obs_q.delete();
        run_step(1'b0, 1'b1, 1, 10, 1'b1, bc);
        check_obs_count("stall_count", 2);
        check_obs("stall_syn0", 0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("stall_no_new_step", m_step % 65536);
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        run_step(1'b1, 1'b0, 0, 0, 1'b0, bc);
        sif.apply = 1'b1;
        @(negedge clk);
        sif.apply = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sif.neuron_done = 1'b1;
        sif.is_spiking1 = 1'b1;
        sif.is_spiking2 = 1'b1;
        @(negedge clk);
        sif.neuron_done = 1'b0;
        sif.is_spiking1 = 1'b0;
        sif.is_spiking2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_quiet("reset_mid_quiet", 0);
            @(negedge clk);
        end
        obs_q.delete();
        run_step(1'b0, 1'b1, 0, 0, 1'b0, bc);
        check_obs_count("reset_mid_ages_invalid", 0);
    endtask

    task automatic test_random();
        int bc;
        bit s1, s2;
        for (int i = 0; i < 40; i++) begin
            s1 = ($urandom_range(2) == 0);
            s2 = ($urandom_range(2) == 0);
            run_step(s1, s2, int'($urandom_range(3)), int'($urandom_range(2)), 1'b0, bc);
            if ($urandom_range(1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        rst             = 1'b1;
        sif.apply       = 1'b0;
        sif.neuron_done = 1'b0;
        sif.is_spiking1 = 1'b0;
        sif.is_spiking2 = 1'b0;
        sif.stdp_ready  = 1'b0;
        model_reset();
        test_reset();
        test_single_step();
        test_min_step();
        test_pair();
        test_both();
        test_window();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
